// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder: default width,
// code-width derivation and the population-count helper.
package prio_enc_pkg;

    localparam int N_DEFAULT = 8;
    localparam int POP_MAX   = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Request vectors narrower than POP_MAX are zero-extended by the caller.
    function automatic int popcount(input logic [POP_MAX-1:0] vec);
        int count;
        count = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            count = count + int'(vec[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/prio_enc_core_v.sv
// Combinational highest-set-index search; idx is 0 when no bit is set.
module prio_enc_core_v
    import prio_enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Later (higher) set bits override earlier ones.
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int k = 0; k < N; k++) begin
            idx = vec[k] ? W'(k) : idx;
        end
    end

endmodule

// File: rtl/priority_enc_n_reg_v.sv
// Registered N-way priority encoder with valid/ready output slot.
// Define PRIORITY_ENC_ROTATE_EN for rotating priority; default is fixed (highest index wins).
module priority_enc_n_reg_v
    import prio_enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    input  logic         i_ready,
    output logic [W-1:0] o_code,
    output logic         o_valid,
    output logic         o_multi
);

    logic [W-1:0] code_r;
    logic         valid_r;
    logic         multi_r;

    logic         slot_free_s;
    logic         accept_s;
    logic         load_valid_s;
    logic         multi_s;
    logic [N-1:0] core_vec_s;
    logic [W-1:0] core_idx_s;
    logic         core_found_s;
    logic [W-1:0] sel_s;

    assign slot_free_s  = ~valid_r | i_ready;
    assign accept_s     = valid_r & i_ready;
    assign load_valid_s = i_en & core_found_s;
    assign multi_s      = (popcount(POP_MAX'(i_req)) > 1);

    prio_enc_core_v #(
        .N (N),
        .W (W)
    ) u_core (
        .vec   (core_vec_s),
        .idx   (core_idx_s),
        .found (core_found_s)
    );

`ifdef PRIORITY_ENC_ROTATE_EN
    localparam logic [W-1:0] PTR_RESET = W'(N - 1);

    logic [W-1:0] ptr_r;
    logic [W-1:0] ptr_eff_s;

    function automatic logic [W-1:0] wrap_idx(input int value);
        return W'(value % N);
    endfunction

    // A sample taken on an accept edge already sees the just-accepted code as lowest priority.
    always_comb begin
        ptr_eff_s = ptr_r;
        if (accept_s) begin
            ptr_eff_s = (code_r == '0) ? PTR_RESET : code_r - W'(1);
        end else begin
            ptr_eff_s = ptr_r;
        end
    end

    // Rotated bit j maps to request (ptr+1+j) mod N, so the pointer lands on the top bit.
    always_comb begin
        core_vec_s = '0;
        for (int j = 0; j < N; j++) begin
            core_vec_s[j] = i_req[wrap_idx(int'(ptr_eff_s) + 1 + j)];
        end
        sel_s = wrap_idx(int'(ptr_eff_s) + 1 + int'(core_idx_s));
    end

    // Rotate pointer moves only when a result is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_r <= PTR_RESET;
        end else if (accept_s) begin
            ptr_r <= ptr_eff_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign core_vec_s = i_req;
    assign sel_s      = core_idx_s;
`endif

    // Output slot: load when free, hold under backpressure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            code_r  <= '0;
            multi_r <= 1'b0;
        end else if (slot_free_s) begin
            valid_r <= load_valid_s;
            if (load_valid_s) begin
                code_r  <= sel_s;
                multi_r <= multi_s;
            end else begin
                code_r  <= '0;
                multi_r <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
            code_r  <= code_r;
            multi_r <= multi_r;
        end
    end

    assign o_code  = code_r;
    assign o_valid = valid_r;
    assign o_multi = multi_r;

endmodule

// File: doc/priority_enc_n_reg_v.md
PRIORITY_ENC_N_REG_V -- requirements
Module: priority_enc_n_reg_v

Interface
REQ-001 SHALL have parameter N, default 8, number of request inputs (N >= 2, need not be a power of two).
REQ-002 SHALL have parameter W, default $clog2(N), code width (3 for N=8).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req  input  N  request vector; bit k = requester k.
REQ-006 SHALL have port i_en  input  1  sample enable.
REQ-007 SHALL have port i_ready  input  1  consumer accepts o_code this cycle.
REQ-008 SHALL have port o_code  output  W  registered index of the selected requester.
REQ-009 SHALL have port o_valid  output  1  o_code holds a pending result.
REQ-010 SHALL have port o_multi  output  1  sampled vector had more than one bit set.

Function
REQ-011 SHALL define slot free = (o_valid==0) or (i_ready==1).
REQ-012 SHALL, on a clock edge with slot free, load o_valid <= i_en && (i_req != 0).
REQ-013 SHALL, on that load with o_valid going to 1, load o_code with the selected index and o_multi with (popcount(i_req) > 1).
REQ-014 SHALL, on that load with o_valid going to 0, load o_code=0 and o_multi=0.
REQ-015 SHALL have a latency of exactly one cycle from sampled i_req to o_code/o_valid; no combinational path from i_req to outputs.
REQ-016 SHALL, while o_valid==1 and i_ready==0, hold o_code, o_valid and o_multi unchanged regardless of i_req and i_en.
REQ-017 SHALL treat o_valid && i_ready as an accept; accept and new sample SHALL occur on the same edge (back-to-back, no bubble).
REQ-018 SHALL, in fixed mode, select the highest set index of i_req.
REQ-019 SHALL never output an index >= N.

Reset
REQ-020 SHALL, on i_rst high, immediately (no clock edge) force o_valid=0, o_code=0, o_multi=0 and the rotate pointer to N-1.
REQ-021 SHALL discard any pending unaccepted result when reset asserts mid-operation.
REQ-022 SHALL take the first sample on the first rising edge with i_rst low.

Configuration
REQ-023 SHALL use macro PRIORITY_ENC_ROTATE_EN to select the priority mode.
REQ-024 SHALL, with PRIORITY_ENC_ROTATE_EN undefined, use fixed priority (REQ-018) and contain no pointer register.
REQ-025 SHALL, with PRIORITY_ENC_ROTATE_EN defined, keep a W-bit pointer ptr (reset N-1) and search ptr, ptr-1, ..., down to 0, then N-1, ..., ptr+1; first set bit wins.
REQ-026 SHALL, on each accept of code k in rotate mode, set ptr <= k-1, wrapping 0 -> N-1 (so k becomes lowest priority).
REQ-027 SHALL leave ptr unchanged when there is no accept, including while held by REQ-016.

Structure
REQ-028 SHALL place the default N, the W derivation (clog2 function) and the popcount helper in shared package prio_enc_pkg.
REQ-029 SHALL implement the combinational highest-index search as sub-module prio_enc_core_v (input N bits, output W-bit index plus any flag); rotate mode SHALL feed it a rotated vector and un-rotate the result.
REQ-030 SHALL hold all registers (o_code, o_valid, o_multi, ptr) in the top module only.

Verification
REQ-031 SHALL cover, for N=8 mid-stream with o_valid=1: raise i_rst between clock edges -> o_valid=0, o_code=0, o_multi=0 before the next edge.
REQ-032 SHALL cover, for N=8 fixed mode: i_req=8'b0010_0110, i_en=1, i_ready=1 -> next cycle o_code=5, o_valid=1, o_multi=1; i_req=8'h08 -> o_code=3, o_multi=0.
REQ-033 SHALL cover backpressure: result o_code=5 valid, i_ready=0, i_req changed to 8'h80 for 3 cycles -> o_code stays 5; raise i_ready -> next cycle o_code=7.
REQ-034 SHALL cover empty or disabled input: i_req=0 or i_en=0 with slot free -> next cycle o_valid=0, o_code=0.
REQ-035 SHALL cover rotate mode, N=8: i_req=8'hFF held, i_ready=1 -> o_code sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
REQ-036 SHALL cover N=5 (W=3) rotate mode: i_req=5'b10001 held, i_ready=1 -> codes 4,0,4,0; wrap of ptr from 0 to 4 observed; no code above 4.
